// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern sequencer and its generator bank.
package pattern_pkg;

  localparam int unsigned NUM_PATTERNS_DEF = 4;
  localparam int unsigned STEP_W           = 3;
  localparam logic [2:0]  STEP_MAX         = 3'd7;

  localparam int unsigned PAT_SPIRAL  = 0;
  localparam int unsigned PAT_PLASMA  = 1;
  localparam int unsigned PAT_CHECKER = 2;
  localparam int unsigned PAT_BARS    = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BLANK  = 2'd1,
    ST_SWITCH = 2'd2
  } seq_state_e;

  // Counter/index width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control inputs and generator-bank outputs of the pattern sequencer.
interface pattern_sequencer_if
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = NUM_PATTERNS_DEF
) ();

  localparam int unsigned SEL_W = idx_width(NUM_PATTERNS);

  logic                    frame_tick;
  logic                    btn_next;
  logic                    btn_up;
  logic                    btn_down;
  logic                    auto_en;
  logic [NUM_PATTERNS-1:0] pattern_enable;
  logic [SEL_W-1:0]        pattern_sel;
  logic [STEP_W-1:0]       step_size;
  logic                    blank;
  logic                    switch_pulse;

  modport master (
    output frame_tick, btn_next, btn_up, btn_down, auto_en,
    input  pattern_enable, pattern_sel, step_size, blank, switch_pulse
  );

  modport slave (
    input  frame_tick, btn_next, btn_up, btn_down, auto_en,
    output pattern_enable, pattern_sel, step_size, blank, switch_pulse
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle press on release->pressed.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Stable level only flips after the synchronised input disagrees for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press    <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Selects the active VGA pattern generator and animation speed, with blanked
// frame-aligned changeovers triggered by the next button or the auto-advance dwell timer.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS    = NUM_PATTERNS_DEF,
  parameter int unsigned DWELL_FRAMES    = 600,
  parameter int unsigned BLANK_FRAMES    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_RESET      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pattern_sequencer_if.slave   bus
);

  localparam int unsigned SEL_W   = idx_width(NUM_PATTERNS);
  localparam int unsigned DWELL_W = idx_width(DWELL_FRAMES);
  localparam int unsigned BCNT_W  = idx_width(BLANK_FRAMES);

  seq_state_e              state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_PATTERNS-1:0] en_q, en_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic                    pend_q, pend_d;
  logic                    blank_q, blank_d;
  logic                    pulse_q, pulse_d;
  logic                    next_p, up_p, down_p;
  logic                    expire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_next), .press(next_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_up),   .press(up_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_down), .press(down_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      sel_q   <= SEL_W'(PAT_SPIRAL);
      en_q    <= NUM_PATTERNS'(1) << PAT_SPIRAL;
      step_q  <= STEP_W'(STEP_RESET);
      dwell_q <= '0;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
      blank_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign expire = bus.auto_en && bus.frame_tick && (dwell_q == DWELL_W'(DWELL_FRAMES - 1));

  // Next-state and register updates; blank/pulse are registered views of the current state.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    bcnt_d  = bcnt_q;
    pend_d  = pend_q;
    blank_d = (state_q != ST_RUN);
    pulse_d = (state_q == ST_SWITCH);

    if (up_p && !down_p && (step_q != STEP_MAX)) begin
      step_d = step_q + STEP_W'(1);
    end else if (down_p && !up_p && (step_q != STEP_W'(0))) begin
      step_d = step_q - STEP_W'(1);
    end

    if (!bus.auto_en) begin
      dwell_d = '0;
    end else if ((state_q == ST_RUN) && bus.frame_tick && !expire) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    unique case (state_q)
      ST_RUN: begin
        if (bus.frame_tick && (pend_q || expire)) begin
          state_d = ST_BLANK;
          bcnt_d  = BCNT_W'(BLANK_FRAMES - 1);
          pend_d  = 1'b0;
        end else if (next_p) begin
          pend_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (bus.frame_tick) begin
          if (bcnt_q == '0) state_d = ST_SWITCH;
          else              bcnt_d  = bcnt_q - BCNT_W'(1);
        end
      end
      ST_SWITCH: begin
        state_d = ST_RUN;
        dwell_d = '0;
        sel_d   = (sel_q == SEL_W'(NUM_PATTERNS - 1)) ? '0 : sel_q + SEL_W'(1);
        en_d    = NUM_PATTERNS'(1) << sel_d;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pattern_sel    = sel_q;
  assign bus.pattern_enable = en_q;
  assign bus.step_size      = step_q;
  assign bus.blank          = blank_q;
  assign bus.switch_pulse   = pulse_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a frame-level reference model.
module tb_pattern_sequencer;

  localparam int NP   = 4;
  localparam int DEB  = 4;
  localparam int DW   = 5;
  localparam int BF   = 2;
  localparam int FRM  = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_sequencer_if #(.NUM_PATTERNS(NP)) bus ();

  pattern_sequencer #(
    .NUM_PATTERNS(NP), .DWELL_FRAMES(DW), .BLANK_FRAMES(BF),
    .DEBOUNCE_CYCLES(DEB), .STEP_RESET(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame-level model: state only advances at frame ticks and settled button presses.
  int m_sel, m_step, m_bcnt, m_dwell, m_switches;
  bit m_blanking, m_pend, m_auto;
  bit settled;
  int pulse_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_step = 3; m_bcnt = 0; m_dwell = 0;
    m_blanking = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_tick();
    if (!m_blanking) begin
      if (m_pend || (m_auto && m_dwell == DW - 1)) begin
        m_blanking = 1'b1; m_bcnt = BF - 1; m_pend = 1'b0;
      end else if (m_auto) begin
        m_dwell++;
      end
    end else if (m_bcnt == 0) begin
      m_sel = (m_sel + 1) % NP;
      m_switches++;
      m_dwell = 0;
      m_blanking = 1'b0;
    end else begin
      m_bcnt--;
    end
  endtask

  task automatic model_press(input bit bn, input bit bu, input bit bd);
    if (bu && !bd && m_step < 7) m_step++;
    if (bd && !bu && m_step > 0) m_step--;
    if (bn && !m_blanking) m_pend = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: tick, settle, optional button hold of 'hold' cycles, settle, idle to FRM cycles.
  task automatic frame(input bit bn, input bit bu, input bit bd, input int hold);
    int used;
    @(posedge clk); #1;
    bus.frame_tick = 1'b1; settled = 1'b0; model_tick();
    cycles(1);
    bus.frame_tick = 1'b0;
    cycles(4);
    settled = 1'b1;
    used = 0;
    if (bn || bu || bd) begin
      settled = 1'b0;
      bus.btn_next = bn; bus.btn_up = bu; bus.btn_down = bd;
      cycles(hold);
      bus.btn_next = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      cycles(14);
      if (hold > DEB) model_press(bn, bu, bd);
      settled = 1'b1;
      used = hold + 14;
    end
    cycles(FRM - 6 - used);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic set_auto(input bit v);
    @(posedge clk); #1;
    bus.auto_en = v; m_auto = v;
    if (!v) m_dwell = 0;
  endtask

  // Per-cycle comparison against the model whenever outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.switch_pulse) pulse_seen++;
      check("enable_onehot", int'($onehot(bus.pattern_enable)), 1);
      if (settled) begin
        check("sel",      int'(bus.pattern_sel),    m_sel);
        check("enable",   int'(bus.pattern_enable), 1 << m_sel);
        check("step",     int'(bus.step_size),      m_step);
        check("blank",    int'(bus.blank),          int'(m_blanking));
        check("pulse_idle", int'(bus.switch_pulse), 0);
        check("switches", pulse_seen,               m_switches);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int base;

  initial begin
    rst_n = 1'b0; settled = 1'b0;
    bus.frame_tick = 1'b0; bus.btn_next = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.auto_en = 1'b0;
    m_auto = 1'b0; m_switches = 0;
    model_reset();
    cycles(3);
    check("rst_sel",    int'(bus.pattern_sel),    0);
    check("rst_enable", int'(bus.pattern_enable), 1);
    check("rst_step",   int'(bus.step_size),      3);
    check("rst_blank",  int'(bus.blank),          0);
    check("rst_pulse",  int'(bus.switch_pulse),   0);
    rst_n = 1'b1;
    cycles(5);
    settled = 1'b1;

    // Held next button: one press, two blank frames, then sel 1.
    frame(1'b1, 1'b0, 1'b0, 20);
    frame(1'b0, 1'b0, 1'b0, 0);
    check("t2_blank_on", int'(bus.blank), 1);
    check("t2_sel_hold", int'(bus.pattern_sel), 0);
    idle(2);
    check("t2_sel",    int'(bus.pattern_sel),    1);
    check("t2_enable", int'(bus.pattern_enable), 2);
    check("t2_blank",  int'(bus.blank),          0);
    check("t2_pulses", pulse_seen,               1);

    // Advance to 3, then wrap to 0.
    for (int i = 0; i < 2; i++) begin
      frame(1'b1, 1'b0, 1'b0, 14);
      idle(3);
    end
    check("wrap_pre_sel", int'(bus.pattern_sel), 3);
    frame(1'b1, 1'b0, 1'b0, 14);
    idle(3);
    check("wrap_sel",    int'(bus.pattern_sel),    0);
    check("wrap_enable", int'(bus.pattern_enable), 1);

    // Reset asserted mid-changeover.
    frame(1'b0, 1'b1, 1'b0, 14);
    frame(1'b1, 1'b0, 1'b0, 14);
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b0, 0);
    check("rst2_pre_blank", int'(bus.blank), 1);
    check("rst2_pre_step",  int'(bus.step_size), 4);
    @(posedge clk); #1;
    settled = 1'b0; rst_n = 1'b0;
    #1;
    check("rst2_sel",    int'(bus.pattern_sel),    0);
    check("rst2_enable", int'(bus.pattern_enable), 1);
    check("rst2_step",   int'(bus.step_size),      3);
    check("rst2_blank",  int'(bus.blank),          0);
    model_reset();
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    settled = 1'b1;
    idle(4);
    check("rst2_no_switch", int'(bus.pattern_sel), 0);

    // Auto-advance: a switch every 7 ticks from a cleared dwell counter.
    base = pulse_seen;
    set_auto(1'b1);
    idle(16);
    check("auto_switches", pulse_seen - base, 2);
    check("auto_sel", int'(bus.pattern_sel), 2);
    set_auto(1'b0);
    idle(1);
    set_auto(1'b1);
    idle(3);
    set_auto(1'b0);
    base = pulse_seen;
    idle(10);
    check("auto_off_switches", pulse_seen - base, 0);

    // Speed saturation and simultaneous up/down.
    for (int i = 0; i < 6; i++) frame(1'b0, 1'b1, 1'b0, 14);
    check("step_max", int'(bus.step_size), 7);
    frame(1'b0, 1'b1, 1'b1, 14);
    check("step_both", int'(bus.step_size), 7);
    for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b1, 14);
    check("step_min", int'(bus.step_size), 0);

    // Glitch ignored; next press during blank discarded.
    base = pulse_seen;
    frame(1'b1, 1'b0, 1'b0, 2);
    idle(3);
    check("glitch_switches", pulse_seen - base, 0);
    frame(1'b1, 1'b0, 1'b0, 14);
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b1, 1'b0, 1'b0, 14);
    idle(5);
    check("blank_press_switches", pulse_seen - base, 1);
    check("blank_press_sel", int'(bus.pattern_sel), 3);

    settled = 1'b0;
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
